uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` transmitter between `NUM_REQ` byte producers, such as the acoustics sample formatter, status reporter and debug console. It sits between the requesters and the `uart_tx` instance. It grants one requester at a time, latches that requester's byte, and pulses `tx_send`. It holds `data_in` stable for the whole frame and waits for the transmitter to go busy and then idle again before granting the next requester.

---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional `UART_ARB_TAG_EN: each grant sends a tag byte (8'h80|g) before the payload byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  input  logic                         uart_ready,
  output logic                         uart_send,
  output logic [DATA_BITS-1:0]         uart_data,
  output logic                         busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_SEND_PAYLOAD
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;
`endif

  state_t               state;
  logic [IDX_W-1:0]     last;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic [DATA_BITS-1:0] grant_byte;

`ifdef UART_ARB_TAG_EN
  logic [DATA_BITS-1:0] payload;
  logic                 payload_pending;
  logic [DATA_BITS-1:0] tag_byte;
`endif

  // Search last+1, last+2, ... (mod NUM_REQ); the first requester found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_valid && req[(int'(last) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
    grant_byte = req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
  end

`ifdef UART_ARB_TAG_EN
  always_comb begin
    tag_byte              = '0;
    tag_byte[DATA_BITS-1] = 1'b1;
    tag_byte[2:0]         = 3'(grant_idx);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      state     <= S_IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      ack       <= '0;
      uart_send <= 1'b0;
      uart_data <= '0;
      busy      <= 1'b0;
`ifdef UART_ARB_TAG_EN
      payload         <= '0;
      payload_pending <= 1'b0;
`endif
    end else begin
      // ack and uart_send are single-cycle pulses unless re-armed below.
      ack       <= '0;
      uart_send <= 1'b0;
      case (state)
        S_IDLE: begin
          if (uart_ready && grant_valid) begin
            ack[grant_idx] <= 1'b1;
            uart_send      <= 1'b1;
            last           <= grant_idx;
            busy           <= 1'b1;
            state          <= S_SEND;
`ifdef UART_ARB_TAG_EN
            uart_data       <= tag_byte;
            payload         <= grant_byte;
            payload_pending <= 1'b1;
`else
            uart_data <= grant_byte;
`endif
          end
        end
        S_SEND: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (!uart_ready) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (uart_ready) begin
`ifdef UART_ARB_TAG_EN
            if (payload_pending) begin
              state <= S_SEND_PAYLOAD;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        S_SEND_PAYLOAD: begin
          uart_data       <= payload;
          uart_send       <= 1'b1;
          payload_pending <= 1'b0;
          state           <= S_WAIT_BUSY;
        end
`endif
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the bench plays the role of uart_tx.ready.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        uart_ready;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic        busy;

  int vectors    = 0;
  int miscompares = 0;
  int ack1_seen  = 0;
  int activity   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .uart_ready (uart_ready),
    .uart_send  (uart_send),
    .uart_data  (uart_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ack[1]) ack1_seen++;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expects a grant at the next edge, then emulates one frame of frame_len busy cycles.
  task automatic do_frame(input string tag, input int idx, input logic [7:0] exp_byte,
                          input int frame_len, input bit drop_req);
    tick();
    check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << idx));
    check({tag, "_send"}, 32'(uart_send), 32'd1);
    check({tag, "_data"}, 32'(uart_data), 32'(exp_byte));
    if (drop_req) req = req & ~(4'b0001 << idx);
    tick();
    check({tag, "_send_pulse"}, 32'({ack, uart_send}), 32'd0);
    uart_ready = 1'b0;
    repeat (frame_len) tick();
    check({tag, "_hold"}, 32'({busy, uart_data}), 32'({1'b1, exp_byte}));
    uart_ready = 1'b1;
    tick();
    check({tag, "_idle"}, 32'({busy, uart_data}), 32'({1'b0, exp_byte}));
  endtask

  initial begin
    reset      = 1'b0;
    req        = 4'b0000;
    req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    uart_ready = 1'b0;
    #2;
    check("reset_outputs", 32'({ack, uart_send, uart_data, busy}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

`ifdef UART_ARB_TAG_EN
    // Tag mode: tag frame 8'h81, then payload 8'hC3, a single ack[1].
    req_data   = {8'h13, 8'h12, 8'hC3, 8'h10};
    req        = 4'b0010;
    uart_ready = 1'b1;
    tick();
    check("tag_ack", 32'(ack), 32'h2);
    check("tag_send", 32'(uart_send), 32'd1);
    check("tag_data", 32'(uart_data), 32'h81);
    req = 4'b0000;
    tick();
    check("tag_send_clear", 32'(uart_send), 32'd0);
    uart_ready = 1'b0;
    repeat (10) tick();
    uart_ready = 1'b1;
    tick();
    check("tag_gap_busy", 32'({busy, uart_send}), 32'b10);
    tick();
    check("payload_send", 32'(uart_send), 32'd1);
    check("payload_data", 32'(uart_data), 32'hC3);
    check("payload_no_ack", 32'(ack), 32'd0);
    tick();
    check("payload_send_clear", 32'(uart_send), 32'd0);
    uart_ready = 1'b0;
    repeat (10) tick();
    check("payload_hold", 32'({busy, uart_data}), 32'h1C3);
    uart_ready = 1'b1;
    tick();
    check("tag_idle", 32'(busy), 32'd0);
    check("tag_ack1_count", 32'(ack1_seen), 32'd1);
`else
    // Single request with a full 8680-cycle frame.
    req_data   = {8'h13, 8'h5A, 8'h11, 8'h10};
    req        = 4'b0100;
    uart_ready = 1'b1;
    do_frame("single", 2, 8'h5A, 8680, 1'b1);

    // Round-robin from a fresh reset (last = 3): order 0,1,2,3,0.
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req      = 4'b1111;
    do_frame("rr0", 0, 8'h10, 12, 1'b0);
    do_frame("rr1", 1, 8'h11, 12, 1'b0);
    do_frame("rr2", 2, 8'h12, 12, 1'b0);
    do_frame("rr3", 3, 8'h13, 12, 1'b0);
    do_frame("rr4", 0, 8'h10, 12, 1'b0);

    // Busy gate: no grant while uart_ready is low.
    uart_ready = 1'b0;
    req        = 4'b0001;
    activity   = 0;
    repeat (100) begin
      tick();
      if (ack != 4'b0000 || uart_send) activity++;
    end
    check("gate_quiet", 32'(activity), 32'd0);
    uart_ready = 1'b1;
    do_frame("gate", 0, 8'h10, 12, 1'b1);

    // Request withdrawn: req[1] raised and dropped during a frame, then req[3].
    ack1_seen = 0;
    req       = 4'b0100;
    tick();
    check("wd_first_ack", 32'(ack), 32'h4);
    req = 4'b0000;
    tick();
    uart_ready = 1'b0;
    req        = 4'b0010;
    repeat (10) tick();
    req = 4'b0000;
    repeat (10) tick();
    uart_ready = 1'b1;
    tick();
    req = 4'b1000;
    do_frame("wd_grant3", 3, 8'h13, 12, 1'b1);
    check("wd_no_ack1", 32'(ack1_seen), 32'd0);

    // Reset mid-frame, in S_WAIT_DONE.
    req = 4'b0001;
    tick();
    check("rm_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    tick();
    uart_ready = 1'b0;
    repeat (6) tick();
    check("rm_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("rm_async_clear", 32'({ack, uart_send, uart_data, busy}), 32'd0);
    tick();
    reset    = 1'b1;
    req      = 4'b0010;
    activity = 0;
    repeat (5) begin
      tick();
      if (ack != 4'b0000 || uart_send) activity++;
    end
    check("rm_wait_ready", 32'(activity), 32'd0);
    uart_ready = 1'b1;
    do_frame("rm_regrant", 1, 8'h11, 12, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
